pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- XLEN, 32, PC width in bits.
- RESET_VEC, 0, PC value loaded on reset.
- INC, 4, sequential increment.
- ALIGN_BITS, 2, low target bits that must be zero.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports, one per line: name direction width meaning.
- PCS_CLK  in  1  clock, all state updates on rising edge.
- PCS_RST  in  1  synchronous active-high reset.
- PCS_STALL  in  1  hold PC this cycle.
- PCS_REDIR_VALID  in  1  branch/jump redirect request.
- PCS_REDIR_TARGET  in  XLEN  redirect target.
- PCS_TRAP  in  1  trap entry request.
- PCS_TRAP_VEC  in  XLEN  trap handler address.
- PCS_MRET  in  1  trap return request.
- PCS_EPC  in  XLEN  return address for MRET.
- PCS_COUNT  out  XLEN  current PC, registered.
- PCS_PREV  out  XLEN  PC value before last update, registered.
- PCS_PENDING  out  1  redirect buffered during stall, registered.
- PCS_MISALIGN  out  1  one-cycle pulse: rejected misaligned redirect, registered.

Function
REQ-003 State machine SHALL have states RUN, HOLD, HOLD_PEND; PCS_PENDING SHALL be 1 exactly in HOLD_PEND.
REQ-004 Per-cycle priority SHALL be: reset > trap > MRET > redirect > stall > sequential.
REQ-005 PCS_TRAP=1 SHALL load PCS_TRAP_VEC with low ALIGN_BITS forced to 0 next edge, regardless of stall or state, clear the pending buffer, enter RUN.
REQ-006 PCS_MRET=1 (no trap) SHALL load PCS_EPC with low ALIGN_BITS forced to 0 next edge, regardless of stall, clear the pending buffer, enter RUN.
REQ-007 Redirect with PCS_STALL=0 and aligned target SHALL load PCS_REDIR_TARGET next edge.
REQ-008 Redirect with PCS_STALL=1 and aligned target SHALL hold PC, write target into pending buffer, enter HOLD_PEND; a later redirect while still in HOLD_PEND SHALL overwrite the buffer.
REQ-009 In HOLD_PEND with PCS_STALL=0 and no new trap/MRET/redirect, PC SHALL load the buffered target, state SHALL return to RUN; a new aligned redirect that cycle SHALL win over the buffer.
REQ-010 Redirect with any nonzero bit in low ALIGN_BITS SHALL not change PC, buffer or state, and SHALL set PCS_MISALIGN for exactly the next cycle.
REQ-011 No request, PCS_STALL=0 in RUN: PC SHALL become PC+INC modulo 2^XLEN (wrap to 0, no flag).
REQ-012 No request, PCS_STALL=1: PC SHALL hold; state RUN->HOLD, HOLD_PEND unchanged.
REQ-013 HOLD with PCS_STALL=0 and no request SHALL increment as REQ-011 and enter RUN.
REQ-014 PCS_PREV SHALL take the old PCS_COUNT on every edge where PCS_COUNT changes, and hold otherwise.
REQ-015 Latency from any accepted request to PCS_COUNT update SHALL be exactly one edge; no combinational path from inputs to outputs.

Reset
REQ-016 On PCS_RST=1 at a rising edge: PCS_COUNT=RESET_VEC, PCS_PREV=RESET_VEC, pending buffer=0, PCS_PENDING=0, PCS_MISALIGN=0, state=RUN.
REQ-017 Reset SHALL override all simultaneous requests and discard any buffered redirect mid-stall.
REQ-018 All outputs SHALL also carry reset values as initial values at time zero.

Structure
REQ-019 A shared package pc_pkg SHALL hold the state enum (RUN, HOLD, HOLD_PEND) and the default XLEN/INC/ALIGN_BITS constants.
REQ-020 The PC register SHALL be one sub-module, pc_reg (parametrised XLEN, load/reset); next-PC selection and FSM SHALL live in pc_sequencer.

Verification
REQ-021 Reset then 3 free cycles (RESET_VEC=0, INC=4) -> PCS_COUNT 0,4,8,12; PCS_PREV 0,0,4,8.
REQ-022 Stall 2 cycles with redirect to 0x100 in stall cycle 1 -> PC held, PCS_PENDING=1; stall release -> PCS_COUNT=0x100, PCS_PENDING=0.
REQ-023 In HOLD_PEND (buffer 0x100), assert PCS_TRAP with PCS_TRAP_VEC=0x203 -> PCS_COUNT=0x200, PCS_PENDING=0, buffer discarded.
REQ-024 Redirect to 0x102 with PC=0x40 -> PCS_COUNT stays 0x40, PCS_MISALIGN=1 for one cycle only.
REQ-025 PC=0xFFFFFFFC, no requests -> PCS_COUNT=0x00000000; simultaneous PCS_TRAP, PCS_MRET, redirect -> trap vector taken.
REQ-026 PCS_RST asserted in HOLD_PEND with PCS_STALL=1 -> next edge PCS_COUNT=RESET_VEC, PCS_PENDING=0, state RUN.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and default
// datapath constants.
package pc_pkg;

  localparam int PC_XLEN       = 32;
  localparam int PC_INC        = 4;
  localparam int PC_ALIGN_BITS = 2;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    HOLD_PEND
  } pcs_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with synchronous reset and load enable; also keeps
// the PC value that was current before the most recent change.
module pc_reg
  import pc_pkg::*;
#(
  parameter int              XLEN      = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] prev
);

  logic [XLEN-1:0] q_r    = RESET_VAL;
  logic [XLEN-1:0] prev_r = RESET_VAL;

  // prev only moves when the PC actually changes, so a load of the same value
  // leaves the history untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= RESET_VAL;
      prev_r <= RESET_VAL;
    end else if (load && (d != q_r)) begin
      prev_r <= q_r;
      q_r    <= d;
    end
  end

  assign q    = q_r;
  assign prev = prev_r;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and stall/redirect FSM: trap > MRET > redirect > stall >
// sequential, with a one-entry buffer for redirects that arrive during a stall.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN       = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              INC        = PC_INC,
  parameter int              ALIGN_BITS = PC_ALIGN_BITS
) (
  input  logic            PCS_CLK,
  input  logic            PCS_RST,
  input  logic            PCS_STALL,
  input  logic            PCS_REDIR_VALID,
  input  logic [XLEN-1:0] PCS_REDIR_TARGET,
  input  logic            PCS_TRAP,
  input  logic [XLEN-1:0] PCS_TRAP_VEC,
  input  logic            PCS_MRET,
  input  logic [XLEN-1:0] PCS_EPC,
  output logic [XLEN-1:0] PCS_COUNT,
  output logic [XLEN-1:0] PCS_PREV,
  output logic            PCS_PENDING,
  output logic            PCS_MISALIGN
);

  localparam logic [XLEN-1:0] LOW_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  localparam logic [XLEN-1:0] INC_V    = XLEN'(INC);

  pcs_state_t      state    = RUN;
  pcs_state_t      nxt_state;
  logic [XLEN-1:0] pend_buf = '0;
  logic [XLEN-1:0] nxt_buf;
  logic            pend_r   = 1'b0;
  logic            mis_r    = 1'b0;
  logic            nxt_mis;
  logic            pc_load;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] pc_prev;
  logic            redir_bad;

  assign redir_bad = |(PCS_REDIR_TARGET & LOW_MASK);

  always_comb begin
    next_pc   = pc_cur;
    pc_load   = 1'b0;
    nxt_state = state;
    nxt_buf   = pend_buf;
    nxt_mis   = 1'b0;
    if (PCS_TRAP) begin
      next_pc   = PCS_TRAP_VEC & ~LOW_MASK;
      pc_load   = 1'b1;
      nxt_state = RUN;
      nxt_buf   = '0;
    end else if (PCS_MRET) begin
      next_pc   = PCS_EPC & ~LOW_MASK;
      pc_load   = 1'b1;
      nxt_state = RUN;
      nxt_buf   = '0;
    end else if (PCS_REDIR_VALID) begin
      // a misaligned target is dropped entirely: PC, buffer and state all hold
      if (redir_bad) begin
        nxt_mis = 1'b1;
      end else if (PCS_STALL) begin
        nxt_buf   = PCS_REDIR_TARGET;
        nxt_state = HOLD_PEND;
      end else begin
        next_pc   = PCS_REDIR_TARGET;
        pc_load   = 1'b1;
        nxt_state = RUN;
        nxt_buf   = '0;
      end
    end else if (PCS_STALL) begin
      if (state == RUN) nxt_state = HOLD;
    end else if (state == HOLD_PEND) begin
      next_pc   = pend_buf;
      pc_load   = 1'b1;
      nxt_state = RUN;
      nxt_buf   = '0;
    end else begin
      next_pc   = pc_cur + INC_V;
      pc_load   = 1'b1;
      nxt_state = RUN;
    end
  end

  always_ff @(posedge PCS_CLK) begin
    if (PCS_RST) begin
      state    <= RUN;
      pend_buf <= '0;
      pend_r   <= 1'b0;
      mis_r    <= 1'b0;
    end else begin
      state    <= nxt_state;
      pend_buf <= nxt_buf;
      pend_r   <= (nxt_state == HOLD_PEND);
      mis_r    <= nxt_mis;
    end
  end

  pc_reg #(
    .XLEN      (XLEN),
    .RESET_VAL (RESET_VEC)
  ) u_pc_reg (
    .clk  (PCS_CLK),
    .rst  (PCS_RST),
    .load (pc_load),
    .d    (next_pc),
    .q    (pc_cur),
    .prev (pc_prev)
  );

  assign PCS_COUNT    = pc_cur;
  assign PCS_PREV     = pc_prev;
  assign PCS_PENDING  = pend_r;
  assign PCS_MISALIGN = mis_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each task drives one scenario and checks
// the registered outputs 1ns after the rising edge.
module tb_pc_sequencer;

  logic        PCS_CLK;
  logic        PCS_RST;
  logic        PCS_STALL;
  logic        PCS_REDIR_VALID;
  logic [31:0] PCS_REDIR_TARGET;
  logic        PCS_TRAP;
  logic [31:0] PCS_TRAP_VEC;
  logic        PCS_MRET;
  logic [31:0] PCS_EPC;
  logic [31:0] PCS_COUNT;
  logic [31:0] PCS_PREV;
  logic        PCS_PENDING;
  logic        PCS_MISALIGN;

  int vectors     = 0;
  int miscompares = 0;

  pc_sequencer dut (
    .PCS_CLK          (PCS_CLK),
    .PCS_RST          (PCS_RST),
    .PCS_STALL        (PCS_STALL),
    .PCS_REDIR_VALID  (PCS_REDIR_VALID),
    .PCS_REDIR_TARGET (PCS_REDIR_TARGET),
    .PCS_TRAP         (PCS_TRAP),
    .PCS_TRAP_VEC     (PCS_TRAP_VEC),
    .PCS_MRET         (PCS_MRET),
    .PCS_EPC          (PCS_EPC),
    .PCS_COUNT        (PCS_COUNT),
    .PCS_PREV         (PCS_PREV),
    .PCS_PENDING      (PCS_PENDING),
    .PCS_MISALIGN     (PCS_MISALIGN)
  );

  initial PCS_CLK = 1'b0;
  always #5 PCS_CLK = ~PCS_CLK;

  task automatic idle();
    PCS_RST = 1'b0; PCS_STALL = 1'b0; PCS_REDIR_VALID = 1'b0; PCS_REDIR_TARGET = '0;
    PCS_TRAP = 1'b0; PCS_TRAP_VEC = '0; PCS_MRET = 1'b0; PCS_EPC = '0;
  endtask

  task automatic tick();
    @(posedge PCS_CLK);
    #1;
  endtask

  task automatic test_reset();
    idle();
    PCS_RST = 1'b1; PCS_TRAP = 1'b1; PCS_TRAP_VEC = 32'h500;
    PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'h600;
    #1;
    vectors++; if (PCS_COUNT !== 32'h0) begin miscompares++; $display("[TB] FAIL t0_count got %h want %h", PCS_COUNT, 32'h0); end
    vectors++; if (PCS_PENDING !== 1'b0 || PCS_MISALIGN !== 1'b0) begin miscompares++; $display("[TB] FAIL t0_flags got %b%b want 00", PCS_PENDING, PCS_MISALIGN); end
    tick();
    vectors++; if (PCS_COUNT !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_count got %h want %h", PCS_COUNT, 32'h0); end
    vectors++; if (PCS_PREV !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_prev got %h want %h", PCS_PREV, 32'h0); end
    vectors++; if (PCS_PENDING !== 1'b0 || PCS_MISALIGN !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_flags got %b%b want 00", PCS_PENDING, PCS_MISALIGN); end
    idle();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_count [3];
    logic [31:0] exp_prev [3];
    exp_count = '{32'h4, 32'h8, 32'hC};
    exp_prev  = '{32'h0, 32'h4, 32'h8};
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (PCS_COUNT !== exp_count[i]) begin miscompares++; $display("[TB] FAIL seq_count[%0d] got %h want %h", i, PCS_COUNT, exp_count[i]); end
      vectors++; if (PCS_PREV !== exp_prev[i]) begin miscompares++; $display("[TB] FAIL seq_prev[%0d] got %h want %h", i, PCS_PREV, exp_prev[i]); end
    end
  endtask

  task automatic test_stall_redirect();
    idle(); PCS_STALL = 1'b1; PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'h100;
    tick();
    vectors++; if (PCS_COUNT !== 32'hC || PCS_PENDING !== 1'b1) begin miscompares++; $display("[TB] FAIL stall1 got %h/%b want %h/1", PCS_COUNT, PCS_PENDING, 32'hC); end
    idle(); PCS_STALL = 1'b1;
    tick();
    vectors++; if (PCS_COUNT !== 32'hC || PCS_PENDING !== 1'b1) begin miscompares++; $display("[TB] FAIL stall2 got %h/%b want %h/1", PCS_COUNT, PCS_PENDING, 32'hC); end
    idle();
    tick();
    vectors++; if (PCS_COUNT !== 32'h100 || PCS_PENDING !== 1'b0) begin miscompares++; $display("[TB] FAIL release got %h/%b want %h/0", PCS_COUNT, PCS_PENDING, 32'h100); end
    vectors++; if (PCS_PREV !== 32'hC) begin miscompares++; $display("[TB] FAIL release_prev got %h want %h", PCS_PREV, 32'hC); end
    tick();
    vectors++; if (PCS_COUNT !== 32'h104) begin miscompares++; $display("[TB] FAIL after_release got %h want %h", PCS_COUNT, 32'h104); end
  endtask

  task automatic test_trap_in_hold_pend();
    idle(); PCS_STALL = 1'b1; PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'h100;
    tick();
    vectors++; if (PCS_PENDING !== 1'b1) begin miscompares++; $display("[TB] FAIL trap_setup got %b want 1", PCS_PENDING); end
    idle(); PCS_STALL = 1'b1; PCS_TRAP = 1'b1; PCS_TRAP_VEC = 32'h203;
    tick();
    vectors++; if (PCS_COUNT !== 32'h200 || PCS_PENDING !== 1'b0) begin miscompares++; $display("[TB] FAIL trap got %h/%b want %h/0", PCS_COUNT, PCS_PENDING, 32'h200); end
    vectors++; if (PCS_PREV !== 32'h104) begin miscompares++; $display("[TB] FAIL trap_prev got %h want %h", PCS_PREV, 32'h104); end
    idle();
    tick();
    vectors++; if (PCS_COUNT !== 32'h204) begin miscompares++; $display("[TB] FAIL trap_discard got %h want %h", PCS_COUNT, 32'h204); end
  endtask

  task automatic test_misalign();
    idle(); PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'h40;
    tick();
    vectors++; if (PCS_COUNT !== 32'h40 || PCS_PREV !== 32'h204) begin miscompares++; $display("[TB] FAIL redir got %h/%h want 40/204", PCS_COUNT, PCS_PREV); end
    PCS_REDIR_TARGET = 32'h102;
    tick();
    vectors++; if (PCS_COUNT !== 32'h40 || PCS_MISALIGN !== 1'b1) begin miscompares++; $display("[TB] FAIL misalign got %h/%b want 40/1", PCS_COUNT, PCS_MISALIGN); end
    vectors++; if (PCS_PREV !== 32'h204) begin miscompares++; $display("[TB] FAIL misalign_prev got %h want %h", PCS_PREV, 32'h204); end
    idle();
    tick();
    vectors++; if (PCS_COUNT !== 32'h44 || PCS_MISALIGN !== 1'b0) begin miscompares++; $display("[TB] FAIL misalign_pulse got %h/%b want 44/0", PCS_COUNT, PCS_MISALIGN); end
    // misaligned redirect during HOLD_PEND must leave the buffer alone
    idle(); PCS_STALL = 1'b1; PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'h300;
    tick();
    PCS_REDIR_TARGET = 32'h333;
    tick();
    vectors++; if (PCS_PENDING !== 1'b1 || PCS_MISALIGN !== 1'b1) begin miscompares++; $display("[TB] FAIL mis_pend got %b%b want 11", PCS_PENDING, PCS_MISALIGN); end
    idle();
    tick();
    vectors++; if (PCS_COUNT !== 32'h300 || PCS_MISALIGN !== 1'b0) begin miscompares++; $display("[TB] FAIL mis_buf got %h/%b want 300/0", PCS_COUNT, PCS_MISALIGN); end
  endtask

  task automatic test_stall_hold();
    idle(); PCS_STALL = 1'b1;
    tick();
    tick();
    vectors++; if (PCS_COUNT !== 32'h300 || PCS_PREV !== 32'h44 || PCS_PENDING !== 1'b0) begin miscompares++; $display("[TB] FAIL hold got %h/%h/%b want 300/44/0", PCS_COUNT, PCS_PREV, PCS_PENDING); end
    idle();
    tick();
    vectors++; if (PCS_COUNT !== 32'h304 || PCS_PREV !== 32'h300) begin miscompares++; $display("[TB] FAIL hold_release got %h/%h want 304/300", PCS_COUNT, PCS_PREV); end
  endtask

  task automatic test_back_to_back();
    idle(); PCS_STALL = 1'b1; PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'h380;
    tick();
    PCS_REDIR_TARGET = 32'h400;
    tick();
    vectors++; if (PCS_COUNT !== 32'h304 || PCS_PENDING !== 1'b1) begin miscompares++; $display("[TB] FAIL overwrite_hold got %h/%b want 304/1", PCS_COUNT, PCS_PENDING); end
    idle();
    tick();
    vectors++; if (PCS_COUNT !== 32'h400) begin miscompares++; $display("[TB] FAIL overwrite got %h want %h", PCS_COUNT, 32'h400); end
    idle(); PCS_STALL = 1'b1; PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'h500;
    tick();
    PCS_STALL = 1'b0; PCS_REDIR_TARGET = 32'h600;
    tick();
    vectors++; if (PCS_COUNT !== 32'h600 || PCS_PENDING !== 1'b0) begin miscompares++; $display("[TB] FAIL new_wins got %h/%b want 600/0", PCS_COUNT, PCS_PENDING); end
    idle();
    tick();
    vectors++; if (PCS_COUNT !== 32'h604) begin miscompares++; $display("[TB] FAIL new_wins_next got %h want %h", PCS_COUNT, 32'h604); end
  endtask

  task automatic test_mret();
    idle(); PCS_STALL = 1'b1; PCS_MRET = 1'b1; PCS_EPC = 32'h1237;
    PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'h40;
    tick();
    vectors++; if (PCS_COUNT !== 32'h1234 || PCS_PREV !== 32'h604) begin miscompares++; $display("[TB] FAIL mret got %h/%h want 1234/604", PCS_COUNT, PCS_PREV); end
    idle();
  endtask

  task automatic test_wrap();
    idle(); PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'hFFFF_FFFC;
    tick();
    idle();
    tick();
    vectors++; if (PCS_COUNT !== 32'h0 || PCS_PREV !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap got %h/%h want 0/fffffffc", PCS_COUNT, PCS_PREV); end
    PCS_TRAP = 1'b1; PCS_TRAP_VEC = 32'h2000; PCS_MRET = 1'b1; PCS_EPC = 32'h3000;
    PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'h4000;
    tick();
    vectors++; if (PCS_COUNT !== 32'h2000) begin miscompares++; $display("[TB] FAIL priority got %h want %h", PCS_COUNT, 32'h2000); end
    idle();
  endtask

  task automatic test_reset_in_hold_pend();
    idle(); PCS_STALL = 1'b1; PCS_REDIR_VALID = 1'b1; PCS_REDIR_TARGET = 32'h700;
    tick();
    idle(); PCS_STALL = 1'b1; PCS_RST = 1'b1;
    tick();
    vectors++; if (PCS_COUNT !== 32'h0 || PCS_PREV !== 32'h0 || PCS_PENDING !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pend got %h/%h/%b want 0/0/0", PCS_COUNT, PCS_PREV, PCS_PENDING); end
    idle();
    tick();
    vectors++; if (PCS_COUNT !== 32'h4 || PCS_PENDING !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pend_run got %h/%b want 4/0", PCS_COUNT, PCS_PENDING); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_trap_in_hold_pend();
    test_misalign();
    test_stall_hold();
    test_back_to_back();
    test_mret();
    test_wrap();
    test_reset_in_hold_pend();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
